// File: rtl/grid_io_param.sv
// Perimeter I/O tile: NUM_SUBTILES GPIO pads configured through a shadow shift chain
// whose contents are copied atomically into the active pad configuration on commit.
module grid_io_param #(
    parameter int NUM_SUBTILES = 4,
    parameter int CFG_BITS     = 2,
    localparam int L           = NUM_SUBTILES * CFG_BITS,
    localparam int CW          = $clog2(L + 1)
) (
    input  logic                     prog_clk,
    input  logic                     pReset,
    input  logic                     ccff_head,
    input  logic                     ccff_shift_en,
    input  logic                     ccff_commit,
    output logic                     ccff_tail,
    inout  wire  [0:NUM_SUBTILES-1]  gfpga_pad_GPIO_PAD,
    input  logic [0:NUM_SUBTILES-1]  outpad,
    output logic [0:NUM_SUBTILES-1]  inpad,
    output logic [CW-1:0]            cfg_bit_count,
    output logic                     cfg_complete
);

    localparam logic [CW-1:0] L_CNT = CW'(L);

    logic [L-1:0]  sr_q, sr_d;
    logic [L-1:0]  act_q, act_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        act_d = act_q;
        cnt_d = cnt_q;
        if (ccff_shift_en) begin
            sr_d = {sr_q[L-2:0], ccff_head};
        end
        // Commit captures the pre-edge shadow value, so a shift on the same edge
        // only lands in the shadow chain and counts as the first bit of a new load.
        if (ccff_commit) begin
            act_d = sr_q;
            cnt_d = CW'(ccff_shift_en);
        end else if (ccff_shift_en && (cnt_q != L_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr_q  <= '0;
            act_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            act_q <= act_d;
            cnt_q <= cnt_d;
        end
    end

    assign ccff_tail     = sr_q[L-1];
    assign cfg_bit_count = cnt_q;
    assign cfg_complete  = (cnt_q == L_CNT);

    // Reserved configuration bits are stored and shifted but drive nothing.
    logic act_unused;
    assign act_unused = ^act_q;

    generate
        for (genvar gi = 0; gi < NUM_SUBTILES; gi++) begin : g_pad
            logic dir;
            logic inv;
            assign dir = act_q[gi*CFG_BITS];
            assign inv = act_q[gi*CFG_BITS + 1];
            assign gfpga_pad_GPIO_PAD[gi] = dir ? (outpad[gi] ^ inv) : 1'bz;
            assign inpad[gi]              = dir ? 1'b0 : (gfpga_pad_GPIO_PAD[gi] ^ inv);
        end
    endgenerate

endmodule

// File: tb/tb_grid_io_param.sv
// Directed bench for grid_io_param: a 4x2 tile for the main scenarios plus
// 8x3 and 1x2 tiles for the parameter sweep.
module tb_grid_io_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: N=4, C=2 ----------------
    logic       a_rst = 1'b1, a_head = 1'b0, a_sh = 1'b0, a_cm = 1'b0;
    logic       a_tail, a_done;
    logic [3:0] a_cnt;
    logic [0:3] a_out = '0, a_in, a_ext_en = '0, a_ext_val = '0;
    wire  [0:3] a_pad;

    // ---------------- instance B: N=8, C=3 ----------------
    logic       b_rst = 1'b1, b_head = 1'b0, b_sh = 1'b0, b_cm = 1'b0;
    logic       b_tail, b_done;
    logic [4:0] b_cnt;
    logic [0:7] b_out = '0, b_in, b_ext_en = '0, b_ext_val = '0;
    wire  [0:7] b_pad;

    // ---------------- instance C: N=1, C=2 ----------------
    logic       c_rst = 1'b1, c_head = 1'b0, c_sh = 1'b0, c_cm = 1'b0;
    logic       c_tail, c_done;
    logic [1:0] c_cnt;
    logic [0:0] c_out = '0, c_in, c_ext_en = '0, c_ext_val = '0;
    wire  [0:0] c_pad;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_a_ext
            assign a_pad[gi] = a_ext_en[gi] ? a_ext_val[gi] : 1'bz;
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_b_ext
            assign b_pad[gi] = b_ext_en[gi] ? b_ext_val[gi] : 1'bz;
        end
    endgenerate
    assign c_pad[0] = c_ext_en[0] ? c_ext_val[0] : 1'bz;

    grid_io_param #(.NUM_SUBTILES(4), .CFG_BITS(2)) dut_a (
        .prog_clk(clk), .pReset(a_rst), .ccff_head(a_head), .ccff_shift_en(a_sh),
        .ccff_commit(a_cm), .ccff_tail(a_tail), .gfpga_pad_GPIO_PAD(a_pad),
        .outpad(a_out), .inpad(a_in), .cfg_bit_count(a_cnt), .cfg_complete(a_done)
    );

    grid_io_param #(.NUM_SUBTILES(8), .CFG_BITS(3)) dut_b (
        .prog_clk(clk), .pReset(b_rst), .ccff_head(b_head), .ccff_shift_en(b_sh),
        .ccff_commit(b_cm), .ccff_tail(b_tail), .gfpga_pad_GPIO_PAD(b_pad),
        .outpad(b_out), .inpad(b_in), .cfg_bit_count(b_cnt), .cfg_complete(b_done)
    );

    grid_io_param #(.NUM_SUBTILES(1), .CFG_BITS(2)) dut_c (
        .prog_clk(clk), .pReset(c_rst), .ccff_head(c_head), .ccff_shift_en(c_sh),
        .ccff_commit(c_cm), .ccff_tail(c_tail), .gfpga_pad_GPIO_PAD(c_pad),
        .outpad(c_out), .inpad(c_in), .cfg_bit_count(c_cnt), .cfg_complete(c_done)
    );

    task automatic a_shift(input logic b);
        a_head = b; a_sh = 1'b1;
        step();
        a_sh = 1'b0;
    endtask

    task automatic b_shift(input logic b);
        b_head = b; b_sh = 1'b1;
        step();
        b_sh = 1'b0;
    endtask

    task automatic c_shift(input logic b);
        c_head = b; c_sh = 1'b1;
        step();
        c_sh = 1'b0;
    endtask

    // Shadow layout sr[7:0] for instance A:
    // sub0 dir=1 inv=0, sub1 dir=0 inv=1, sub2 dir=1 inv=1, sub3 dir=0 inv=0
    logic [7:0]  a_cfg = 8'b0011_1001;
    logic [7:0]  a_mdl;
    logic [3:0]  a_pat = 4'b1001;
    logic [23:0] b_cfg;
    logic [23:0] b_mdl;
    logic [1:0]  c_mdl;

    initial begin
        // ---------- 1. reset state ----------
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        #1;
        check("rst_tail",  {31'b0, a_tail}, 32'd0);
        check("rst_count", {28'b0, a_cnt},  32'd0);
        check("rst_done",  {31'b0, a_done}, 32'd0);
        a_ext_en = 4'b1111; a_ext_val = 4'b1010;
        #1;
        check("rst_inpad", {28'b0, a_in}, 32'b1010);

        // ---------- 2. full load and commit ----------
        for (int i = 7; i >= 0; i--) a_shift(a_cfg[i]);
        check("load_count", {28'b0, a_cnt},  32'd8);
        check("load_done",  {31'b0, a_done}, 32'd1);
        a_ext_val = 4'b0101;
        #1;
        check("load_pads_unchanged", {28'b0, a_in}, 32'b0101);
        a_ext_en = 4'b0101; a_ext_val = 4'b0000; a_out = 4'b1111;
        a_cm = 1'b1;
        step();
        a_cm = 1'b0;
        check("commit_pad0",  {31'b0, a_pad[0]}, 32'd1);
        check("commit_pad2",  {31'b0, a_pad[2]}, 32'd0);
        check("commit_inpad", {28'b0, a_in},     32'b0100);
        check("commit_count", {28'b0, a_cnt},    32'd0);
        check("commit_done",  {31'b0, a_done},   32'd0);

        // ---------- 3. pass-through and saturation ----------
        a_mdl = a_cfg;
        for (int j = 0; j < 12; j++) begin
            a_shift(a_pat[3 - (j % 4)]);
            a_mdl = {a_mdl[6:0], a_pat[3 - (j % 4)]};
            check($sformatf("pass_tail_%0d", j),  {31'b0, a_tail}, {31'b0, a_mdl[7]});
            check($sformatf("pass_count_%0d", j), {28'b0, a_cnt},  (j < 8) ? j + 1 : 8);
        end
        check("pass_pad0_live", {31'b0, a_pad[0]}, 32'd1);
        check("pass_done",      {31'b0, a_done},   32'd1);

        // ---------- 4. simultaneous shift + commit ----------
        for (int i = 0; i < 8; i++) a_shift(1'b1);
        a_ext_en = 4'b0000; a_out = 4'b1010;
        a_head = 1'b0; a_sh = 1'b1; a_cm = 1'b1;
        step();
        a_sh = 1'b0; a_cm = 1'b0;
        check("shcm_pads",  {28'b0, a_pad}, 32'b0101);
        check("shcm_inpad", {28'b0, a_in},  32'b0000);
        check("shcm_count", {28'b0, a_cnt}, 32'd1);
        for (int i = 0; i < 6; i++) a_shift(1'b1);
        check("shcm_tail_sr1", {31'b0, a_tail}, 32'd1);
        a_shift(1'b1);
        check("shcm_tail_sr0", {31'b0, a_tail}, 32'd0);

        // ---------- 5. reset mid-load ----------
        for (int i = 0; i < 5; i++) a_shift(1'b1);
        a_rst = 1'b1; a_head = 1'b1; a_sh = 1'b1; a_cm = 1'b1;
        step();
        a_rst = 1'b0; a_sh = 1'b0; a_cm = 1'b0;
        check("midrst_count", {28'b0, a_cnt},  32'd0);
        check("midrst_tail",  {31'b0, a_tail}, 32'd0);
        check("midrst_done",  {31'b0, a_done}, 32'd0);
        a_ext_en = 4'b1111; a_ext_val = 4'b0110;
        #1;
        check("midrst_inpad", {28'b0, a_in}, 32'b0110);
        for (int i = 0; i < 7; i++) a_shift(1'b1);
        check("midrst_sr_clear", {31'b0, a_tail}, 32'd0);
        a_shift(1'b1);
        check("midrst_tail_8", {31'b0, a_tail}, 32'd1);

        // ---------- 6a. sweep N=8, C=3 ----------
        // subtile k: dir=k[0], inv=k[1], reserved=1
        for (int k = 0; k < 8; k++) begin
            b_cfg[3*k]     = k[0];
            b_cfg[3*k + 1] = k[1];
            b_cfg[3*k + 2] = 1'b1;
        end
        for (int i = 23; i >= 0; i--) b_shift(b_cfg[i]);
        check("b_load_count", {27'b0, b_cnt},  32'd24);
        check("b_load_done",  {31'b0, b_done}, 32'd1);
        b_out = 8'hFF; b_ext_en = 8'b1010_1010; b_ext_val = 8'b1010_1010;
        b_cm = 1'b1;
        step();
        b_cm = 1'b0;
        check("b_pad1",  {31'b0, b_pad[1]}, 32'd1);
        check("b_pad3",  {31'b0, b_pad[3]}, 32'd0);
        check("b_pad5",  {31'b0, b_pad[5]}, 32'd1);
        check("b_pad7",  {31'b0, b_pad[7]}, 32'd0);
        check("b_inpad", {24'b0, b_in},     32'b1000_1000);
        check("b_commit_count", {27'b0, b_cnt}, 32'd0);
        b_mdl = b_cfg;
        for (int j = 0; j < 30; j++) begin
            b_shift(a_pat[3 - (j % 4)]);
            b_mdl = {b_mdl[22:0], a_pat[3 - (j % 4)]};
            check($sformatf("b_pass_tail_%0d", j), {31'b0, b_tail}, {31'b0, b_mdl[23]});
        end
        check("b_sat_count", {27'b0, b_cnt},  32'd24);
        check("b_sat_done",  {31'b0, b_done}, 32'd1);

        // ---------- 6b. sweep N=1, C=2 ----------
        check("c_rst_count", {30'b0, c_cnt}, 32'd0);
        c_shift(1'b1);
        c_shift(1'b1);
        check("c_load_done", {31'b0, c_done}, 32'd1);
        c_out = 1'b0;
        c_cm = 1'b1;
        step();
        c_cm = 1'b0;
        check("c_pad_inv", {31'b0, c_pad[0]}, 32'd1);
        check("c_inpad",   {31'b0, c_in[0]},  32'd0);
        c_mdl = 2'b11;
        for (int j = 0; j < 6; j++) begin
            c_shift(a_pat[3 - (j % 4)]);
            c_mdl = {c_mdl[0], a_pat[3 - (j % 4)]};
            check($sformatf("c_pass_tail_%0d", j), {31'b0, c_tail}, {31'b0, c_mdl[1]});
        end
        check("c_sat_count", {30'b0, c_cnt}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_io_param.md
# grid_io_param

Parametrised I/O grid tile: NUM_SUBTILES GPIO pads, each with its own configuration field, loaded through a single configuration-chain shift register. The chain runs ccff_head → subtile 0 → … → subtile N-1 → ccff_tail. Unlike the fixed two-pad I/O tile, it adds:
- a shadow/active split, so a new configuration is applied atomically on a commit strobe;
- per-pad direction and polarity control;
- a shifted-bit counter that tells the configuration controller when the chain is fully loaded.

It sits on the fabric perimeter, between the routing channels and the chip pads.

## Interface
- NUM_SUBTILES, default 4: number of pads/subtiles (≥1).
- CFG_BITS, default 2: configuration bits per subtile (≥2). Bit 0 is dir (1 = output). Bit 1 is inv (1 = invert both directions). Bits ≥2 are reserved: stored and shifted, no function.
- Derived: L = NUM_SUBTILES*CFG_BITS; CW = clog2(L+1).

Ports:
- prog_clk  in  1  sole clock; all state updates on rising edge.
- pReset  in  1  synchronous, active-high reset.
- ccff_head  in  1  serial configuration data in.
- ccff_shift_en  in  1  shift the chain one position this cycle.
- ccff_commit  in  1  copy shadow chain into the active configuration.
- ccff_tail  out  1  serial configuration data out = sr[L-1].
- gfpga_pad_GPIO_PAD  inout  [0:NUM_SUBTILES-1]  chip pads.
- outpad  in  [0:NUM_SUBTILES-1]  fabric → pad data.
- inpad  out  [0:NUM_SUBTILES-1]  pad → fabric data.
- cfg_bit_count  out  CW  bits shifted since last reset/commit, saturating at L.
- cfg_complete  out  1  high when cfg_bit_count == L.

## Operation
- **Shadow chain sr[0:L-1].** When ccff_shift_en=1: sr[0] ← ccff_head, sr[i] ← sr[i-1]. Otherwise sr holds.
- **Field mapping.** Subtile k's field is sr[k*CFG_BITS + j], j = 0..CFG_BITS-1. After L shifts, the first bit shifted in sits in sr[L-1], i.e. the highest bit of subtile N-1.
- **Active register act[0:L-1].** On ccff_commit=1: act ← sr, using the pre-edge sr value, even if a shift occurs on the same edge. Otherwise act holds. Only act drives the pads; shifting never disturbs live pads.
- **Pad behaviour per subtile k**, with dir = act[k*C+0] and inv = act[k*C+1]:
  - dir=1: pad k driven with outpad[k]^inv; inpad[k]=0.
  - dir=0: pad k high-Z; inpad[k] = pad[k]^inv.
  - Pad paths are combinational.
- **Counter update.** On commit, cfg_bit_count ← (ccff_shift_en ? 1 : 0). Otherwise, on shift, cfg_bit_count ← min(count+1, L). Otherwise it holds.
- **cfg_complete** is decoded combinationally from the registered counter.
- **Over-shifting.** Shifting past L is legal: bits continue to ccff_tail and the counter stays at L.
- **Reset (pReset=1)** has priority over shift and commit on the same edge. Reset values:
  - sr = 0, act = 0, cfg_bit_count = 0.
  - Hence ccff_tail = 0, cfg_complete = 0.
  - All pads high-Z; inpad = raw pad value.
- **Reset mid-load** discards partial shadow contents. Nothing is committed.

## Timing
- ccff_tail reflects ccff_head L edges after it was shifted in, with shift_en high on each of those edges.
- **Commit latency.** Pad/inpad behaviour changes in the cycle after the commit edge; this is combinational from act.
- **cfg_bit_count / cfg_complete** update one edge after each shift or commit.
- **outpad→pad and pad→inpad** have zero cycles of latency; there is no registering in the data path.
- **shift_en, commit and pReset** are sampled only at prog_clk rising edges. There are no asynchronous paths.

## Test plan
1. **Reset state.** Assert pReset 2 cycles, then release.
   - Required: ccff_tail=0, count=0, complete=0, all pads Z.
   - Then drive pads 4'b1010 externally → inpad=4'b1010.
2. **Full load and commit.** N=4, C=2. Shift 8 bits so the final sr = {sub0: dir=1,inv=0; sub1: dir=0,inv=1; sub2: dir=1,inv=1; sub3: dir=0,inv=0}.
   - After the 8th shift: count=8, complete=1; pads still unchanged.
   - After commit with outpad=4'b1111 and external pads 1,3 = 0: pad0=1, pad2=0, inpad[1]=1, inpad[3]=0, inpad[0]=inpad[2]=0; count=0.
3. **Pass-through and saturation.** Shift 12 bits of pattern 1,0,0,1,…
   - Required: ccff_tail reproduces each head bit 8 edges later; count sticks at 8.
4. **Simultaneous shift+commit.** With sr = all-ones, assert shift_en=1 (head=0) and commit on the same edge.
   - Required: act = all-ones (pre-shift value), sr[0]=0, count=1.
5. **Reset mid-load.** Shift 5 bits, assert pReset on the same edge as a shift_en+commit.
   - Required: sr=act=0, count=0; pads remain Z.
6. **Parameter sweep.** Repeat scenarios 2–3 for (N,C) = (1,2), (2,2), (8,3).
   - Required: the tail delay equals L; the reserved bit is shifted but has no pad effect.
